// File: rtl/wbuf_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wbuf_pkg : shared widths, FSM encoding and entry type for write_buffer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package wbuf_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RESP = 2'd2,
        S_WR   = 2'd3
    } wbuf_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wbuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/wbuf_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wbuf_fifo : circular write-entry store with youngest-match lookup     |
// | Optional: WBUF_COALESCE_EN (in-place data update). Rev 1.0            |
// +-----------------------------------------------------------------------+
module wbuf_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
`ifdef WBUF_COALESCE_EN
    input  logic              upd_i,
    input  logic              draining_i,
    output logic              coal_hit_o,
`endif
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  w_slot_idx [DEPTH];
    logic [DEPTH-1:0]  w_match;
    logic [PTR_W-1:0]  w_hit_idx;

    // Slot i is the i-th oldest entry, so the last match in age order is the youngest.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            assign w_slot_idx[i] = head_q + PTR_W'(i);
            assign w_match[i]    = (CNT_W'(i) < count_q) && (addr_q[w_slot_idx[i]] == addr_i);
        end
    endgenerate

    always_comb begin
        hit_o     = 1'b0;
        w_hit_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                hit_o     = 1'b1;
                w_hit_idx = w_slot_idx[i];
            end
        end
    end

`ifdef WBUF_COALESCE_EN
    assign coal_hit_o = hit_o && !(draining_i && (w_hit_idx == head_q));
`endif

    assign hit_data_o  = data_q[w_hit_idx];
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CNT_W'(DEPTH));

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + PTR_W'(1);
        if (pop_i)  head_d = head_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_q[tail_q] <= addr_i;
            data_q[tail_q] <= wr_data_i;
        end
`ifdef WBUF_COALESCE_EN
        else if (upd_i) begin
            data_q[w_hit_idx] <= wr_data_i;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | write_buffer : posted-write FIFO between D-cache and memory, with     |
// | read forwarding. Optional: WBUF_COALESCE_EN. Rev 1.0                  |
// +-----------------------------------------------------------------------+
module write_buffer
    import wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              empty
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wbuf_state_e       state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              w_hit, w_full, w_push, w_pop, w_rd_miss, w_wr_stall;
    logic [DATA_W-1:0] w_hit_data, w_head_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [CNT_W-1:0]  w_count;

`ifdef WBUF_COALESCE_EN
    logic w_coal_hit, w_upd;
    assign w_push     = write && !w_coal_hit && !w_full;
    assign w_upd      = write && w_coal_hit;
    assign w_wr_stall = w_full && !w_coal_hit;
`else
    assign w_push     = write && !w_full;
    assign w_wr_stall = w_full;
`endif

    assign w_pop     = (state_q == S_WR) && !mem_busywait;
    assign w_rd_miss = read && !write && !w_hit;

    wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RESET),
        .push_i      (w_push),
        .pop_i       (w_pop),
`ifdef WBUF_COALESCE_EN
        .upd_i       (w_upd),
        .draining_i  (state_q == S_WR),
        .coal_hit_o  (w_coal_hit),
`endif
        .addr_i      (address),
        .wr_data_i   (writedata),
        .hit_o       (w_hit),
        .hit_data_o  (w_hit_data),
        .head_addr_o (w_head_addr),
        .head_data_o (w_head_data),
        .count_o     (w_count),
        .full_o      (w_full)
    );

    // A write takes precedence over a simultaneous read; a miss is released only in RESP.
    always_comb begin
        busywait = 1'b0;
        if (write)     busywait = w_wr_stall;
        else if (read) busywait = !w_hit && (state_q != S_RESP);
    end

    assign readdata = w_hit ? w_hit_data : rdata_q;
    assign empty    = (w_count == '0) && (state_q == S_IDLE || state_q == S_RESP);

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_q)
            S_IDLE: begin
                if (w_rd_miss)            state_d = S_RD;
                else if (w_count != '0)   state_d = S_WR;
            end
            S_RD: begin
                mem_read    = 1'b1;
                mem_address = address;
                if (!mem_busywait) begin
                    rdata_d = mem_readdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            S_WR: begin
                mem_write     = 1'b1;
                mem_address   = w_head_addr;
                mem_writedata = w_head_data;
                if (!mem_busywait) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_write_buffer : directed + random bench for write_buffer            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_write_buffer;
    import wbuf_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = ADDR_W_DEF;
    localparam int DW    = DATA_W_DEF;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] writedata = '0;
    logic [DW-1:0] readdata;
    logic          busywait;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata, mem_readdata;
    logic          mem_busywait;
    logic          empty;

    always #5 CLK = ~CLK;

    write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .empty         (empty)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    // Memory: busy for mem_lat cycles per access, completes when busywait falls.
    logic [DW-1:0]     mem_arr [2**AW];
    logic [2**AW-1:0]  mem_valid = '0;
    int                lat_cnt = 0;
    int                mem_lat = 5;
    wbuf_entry_t       wlog [$];

    assign mem_busywait = (mem_read || mem_write) && (lat_cnt < mem_lat);
    assign mem_readdata = !mem_read ? '0 :
                          (mem_valid[mem_address] ? mem_arr[mem_address] : init_val(mem_address));

    always @(posedge CLK) begin
        if (!RESET) begin
            lat_cnt <= 0;
        end else if (mem_read || mem_write) begin
            if (mem_busywait) begin
                lat_cnt <= lat_cnt + 1;
            end else begin
                lat_cnt <= 0;
                if (mem_write) begin
                    mem_arr[mem_address]   <= mem_writedata;
                    mem_valid[mem_address] <= 1'b1;
                    wlog.push_back({mem_address, mem_writedata});
                end
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    // Reference model: pending entries in acceptance order plus drained memory image.
    wbuf_entry_t      pend_q [$];
    logic [DW-1:0]    exp_mem [2**AW];
    logic [2**AW-1:0] exp_valid;
    int               tests = 0;
    int               fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain_log();
        wbuf_entry_t e, x;
        while (wlog.size() > 0) begin
            e = wlog.pop_front();
            if (pend_q.size() > 0) begin
                x = pend_q.pop_front();
                chk("drain_addr", 64'(e.addr), 64'(x.addr));
                chk("drain_data", 64'(e.data), 64'(x.data));
                exp_mem[x.addr]   = x.data;
                exp_valid[x.addr] = 1'b1;
            end else begin
                chk("drain_spurious", 64'(e), '1);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drain_log();
        chk("count", 64'(dut.u_fifo.count_o), 64'(pend_q.size()));
    endtask

    task automatic model_rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit hit);
        hit = 1'b0;
        d   = exp_valid[a] ? exp_mem[a] : init_val(a);
        foreach (pend_q[i]) begin
            if (pend_q[i].addr == a) begin
                hit = 1'b1;
                d   = pend_q[i].data;
            end
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
        bit          exp_busy;
        int          coal_idx;
        wbuf_entry_t e;
        write = 1'b1; address = a; writedata = d;
        waited = 0;
        forever begin
            @(negedge CLK);
            coal_idx = -1;
`ifdef WBUF_COALESCE_EN
            foreach (pend_q[i])
                if (pend_q[i].addr == a && !(i == 0 && mem_write)) coal_idx = i;
`endif
            exp_busy = (pend_q.size() == DEPTH) && (coal_idx < 0);
            chk("wr_busywait", 64'(busywait), 64'(exp_busy));
            if (!busywait) begin
                if (coal_idx >= 0) begin
                    e = pend_q[coal_idx];
                    e.data = d;
                    pend_q[coal_idx] = e;
                end else begin
                    pend_q.push_back({a, d});
                end
                break;
            end
            if (waited >= 200) begin
                chk("wr_timeout", 64'(busywait), 64'(0));
                break;
            end
            waited++;
            tick();
        end
        tick();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit hold_extra);
        logic [DW-1:0] exp_d;
        bit            exp_hit;
        int            waited;
        read = 1'b1; address = a; waited = 0;
        model_rd(a, exp_d, exp_hit);
        forever begin
            @(negedge CLK);
            if (!busywait || exp_hit || waited >= 300) break;
            waited++;
            tick();
        end
        chk("rd_busywait", 64'(busywait), 64'(0));
        chk("rd_data", 64'(readdata), 64'(exp_d));
        if (exp_hit) chk("rd_hit_no_memread", 64'(mem_read), 64'(0));
        else         chk("rd_miss_stalled", 64'(waited > 0), 64'(1));
        tick();
        if (hold_extra) begin
            @(negedge CLK);
            chk("resp_one_cycle", 64'(busywait), 64'(1));
            tick();
        end
        read = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (!(empty === 1'b1 && mem_read === 1'b0) && n < 300) begin
            tick();
            @(negedge CLK);
            n++;
        end
        chk("idle_empty", 64'(empty), 64'(1));
        chk("idle_model", 64'(pend_q.size()), 64'(0));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n_pend;
        exp_valid = '0;

        // Reset state
        tick();
        tick();
        @(negedge CLK);
        chk("rst_busywait", 64'(busywait), 64'(0));
        chk("rst_readdata", 64'(readdata), 64'(0));
        chk("rst_mem_read", 64'(mem_read), 64'(0));
        chk("rst_mem_write", 64'(mem_write), 64'(0));
        chk("rst_mem_address", 64'(mem_address), 64'(0));
        chk("rst_mem_writedata", 64'(mem_writedata), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        tick();
        RESET = 1'b1;

        // Single write drains to memory
        mem_lat = 5;
        do_write(6'h05, 32'hDEADBEEF, w);
        chk("t1_no_stall", 64'(w), 64'(0));
        tick();
        @(negedge CLK);
        chk("t1_mem_write", 64'(mem_write), 64'(1));
        chk("t1_mem_address", 64'(mem_address), 64'(6'h05));
        chk("t1_mem_wdata", 64'(mem_writedata), 64'(32'hDEADBEEF));
        tick();
        wait_idle();

        // Five back-to-back writes into a 4-deep buffer
        for (int i = 1; i <= 5; i++) begin
            do_write(AW'(i), $urandom, w);
            if (i == 5) chk("t2_fifth_stalled", 64'(w > 0), 64'(1));
        end
        wait_idle();

        // Forwarding hit right after write
        do_write(6'h0A, 32'h11223344, w);
        do_read(6'h0A, 1'b0);
        wait_idle();

        // Duplicate address: youngest wins
        do_write(6'h0A, 32'hAAAA0000, w);
        do_write(6'h0A, 32'hBBBB1111, w);
`ifdef WBUF_COALESCE_EN
        chk("t4_count", 64'(dut.u_fifo.count_o), 64'(1));
`else
        chk("t4_count", 64'(dut.u_fifo.count_o), 64'(2));
`endif
        do_read(6'h0A, 1'b0);
        wait_idle();

        // Read miss during an in-flight drain
        for (int i = 0; i < 3; i++) do_write(AW'(6'h10 + i), $urandom, w);
        @(negedge CLK);
        chk("t5_in_wr", 64'(mem_write), 64'(1));
        tick();
        n_pend = pend_q.size();
        do_read(6'h3F, 1'b1);
        chk("t5_read_beats_drain", 64'(pend_q.size()), 64'(n_pend - 1));
        wait_idle();

        // Reset during a drain with three entries queued
        for (int i = 0; i < 3; i++) do_write(AW'(6'h20 + i), $urandom, w);
        @(negedge CLK);
        chk("t6_pre_count", 64'(dut.u_fifo.count_o), 64'(3));
        chk("t6_pre_wr", 64'(mem_write), 64'(1));
        tick();
        RESET = 1'b0;
        pend_q.delete();
        tick();
        @(negedge CLK);
        chk("t6_mem_write", 64'(mem_write), 64'(0));
        chk("t6_empty", 64'(empty), 64'(1));
        chk("t6_busywait", 64'(busywait), 64'(0));
        tick();
        RESET = 1'b1;

        // Randomized mix against the model
        for (int r = 0; r < 3; r++) begin
            mem_lat = $urandom_range(0, 4);
            for (int k = 0; k < 25; k++) begin
                if ($urandom_range(0, 2) < 2) do_write(AW'($urandom_range(0, 15)), $urandom, w);
                else                          do_read(AW'($urandom_range(0, 15)), 1'b0);
            end
            wait_idle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
